// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_JALR = 6'b001001;

  localparam logic [1:0] NPC_PC4  = 2'd0;
  localparam logic [1:0] NPC_BR   = 2'd1;
  localparam logic [1:0] NPC_JMP  = 2'd2;
  localparam logic [1:0] NPC_REG  = 2'd3;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  localparam logic [1:0] WD_ALU   = 2'd0;
  localparam logic [1:0] WD_DM    = 2'd1;
  localparam logic [1:0] WD_PC    = 2'd2;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;
  localparam logic [2:0] ALU_LUI  = 3'd3;

  // One-hot instruction class; all-zero means undecoded.
  typedef struct packed {
    logic addu;
    logic subu;
    logic jalr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
  } cls_t;

endpackage

// File: rtl/mc_if.sv
// Controller <-> datapath bundle: IR fields and flags in, selects/enables out.
interface mc_if #(parameter int CNT_W = 32);
  logic             stall;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic             zero;
  logic             pc_we;
  logic [1:0]       npc_sel;
  logic             ir_we;
  logic             reg_we;
  logic [1:0]       regdst;
  logic [1:0]       wd_sel;
  logic             alusrc;
  logic [2:0]       aluop;
  logic             extop;
  logic             mem_we;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_cnt;
  logic             illegal;

  // Datapath side
  modport master (
    output stall, opcode, funct, zero,
    input  pc_we, npc_sel, ir_we, reg_we, regdst, wd_sel, alusrc, aluop,
           extop, mem_we, state, instr_cnt, illegal
  );

  // Controller side
  modport slave (
    input  stall, opcode, funct, zero,
    output pc_we, npc_sel, ir_we, reg_we, regdst, wd_sel, alusrc, aluop,
           extop, mem_we, state, instr_cnt, illegal
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct -> one-hot class + illegal.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output cls_t       cls_o,
  output logic       illegal_o
);

  // Class lookup; anything not matched leaves the vector empty.
  always_comb begin
    cls_o = '0;
    unique case (opcode_i)
      OP_R: begin
        unique case (funct_i)
          FN_ADDU: cls_o.addu = 1'b1;
          FN_SUBU: cls_o.subu = 1'b1;
          FN_JALR: cls_o.jalr = 1'b1;
          default: ;
        endcase
      end
      OP_ORI:  cls_o.ori = 1'b1;
      OP_LUI:  cls_o.lui = 1'b1;
      OP_LW:   cls_o.lw  = 1'b1;
      OP_SW:   cls_o.sw  = 1'b1;
      OP_BEQ:  cls_o.beq = 1'b1;
      OP_J:    cls_o.j   = 1'b1;
      OP_JAL:  cls_o.jal = 1'b1;
      default: ;
    endcase
  end

  assign illegal_o = ~|cls_o;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller: IF/ID/EXE/MEM/WB FSM, output decode,
// retired-instruction counter.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset,   // async, active low
  mc_if.slave  bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cls_t             cls;
  logic             dec_ill;
  logic             last;   // current state is the final one of this instruction
  logic             we_ok;

  mc_decode u_dec (
    .opcode_i  (bus.opcode),
    .funct_i   (bus.funct),
    .cls_o     (cls),
    .illegal_o (dec_ill)
  );

  // Writes only happen out of reset and when not held.
  assign we_ok = reset & ~bus.stall;

  // Next state and retire detection; stall freezes both state and count.
  always_comb begin
    state_d = state_q;
    last    = 1'b0;
    unique case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  if (cls.j | cls.jal | cls.jalr | dec_ill) last = 1'b1;
             else                                       state_d = S_EXE;
      S_EXE: if (cls.beq)             last = 1'b1;
             else if (cls.lw | cls.sw) state_d = S_MEM;
             else                      state_d = S_WB;
      S_MEM: if (cls.sw) last = 1'b1;
             else        state_d = S_WB;
      S_WB:  last = 1'b1;
      default: state_d = S_IF;
    endcase
    if (last) state_d = S_IF;
    if (bus.stall) state_d = state_q;
    cnt_d = cnt_q + CNT_W'(last & ~bus.stall);
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode; ALU selects persist from EXE through WB so the result
  // stays valid while it is being stored.
  always_comb begin
    logic pc_we_r, ir_we_r, reg_we_r, mem_we_r;
    pc_we_r      = 1'b0;
    ir_we_r      = 1'b0;
    reg_we_r     = 1'b0;
    mem_we_r     = 1'b0;
    bus.npc_sel  = NPC_PC4;
    bus.regdst   = RD_RT;
    bus.wd_sel   = WD_ALU;
    bus.alusrc   = 1'b0;
    bus.aluop    = ALU_ADD;
    bus.extop    = 1'b0;

    if (state_q == S_EXE || state_q == S_MEM || state_q == S_WB) begin
      if (cls.subu) bus.aluop = ALU_SUB;
      if (cls.ori) begin
        bus.alusrc = 1'b1;
        bus.aluop  = ALU_OR;
      end
      if (cls.lui) begin
        bus.alusrc = 1'b1;
        bus.aluop  = ALU_LUI;
      end
      if (cls.lw | cls.sw) begin
        bus.alusrc = 1'b1;
        bus.extop  = 1'b1;
      end
      if (cls.beq) begin
        bus.aluop = ALU_SUB;
        bus.extop = 1'b1;
      end
    end

    unique case (state_q)
      S_IF: begin
        ir_we_r = 1'b1;
        pc_we_r = 1'b1;
      end
      S_ID: begin
        if (cls.j | cls.jal) begin
          pc_we_r     = 1'b1;
          bus.npc_sel = NPC_JMP;
        end
        if (cls.jalr) begin
          pc_we_r     = 1'b1;
          bus.npc_sel = NPC_REG;
        end
        if (cls.jal | cls.jalr) begin
          reg_we_r   = 1'b1;
          bus.wd_sel = WD_PC;
          bus.regdst = cls.jal ? RD_RA : RD_RD;
        end
      end
      S_EXE: begin
        if (cls.beq) begin
          pc_we_r     = bus.zero;
          bus.npc_sel = NPC_BR;
        end
      end
      S_MEM: mem_we_r = cls.sw;
      S_WB: begin
        reg_we_r = 1'b1;
        if (cls.addu | cls.subu) bus.regdst = RD_RD;
        if (cls.lw)              bus.wd_sel = WD_DM;
      end
      default: ;
    endcase

    bus.pc_we  = pc_we_r  & we_ok;
    bus.ir_we  = ir_we_r  & we_ok;
    bus.reg_we = reg_we_r & we_ok;
    bus.mem_we = mem_we_r & we_ok;
  end

  assign bus.illegal   = reset & (state_q == S_ID) & dec_ill;
  assign bus.state     = state_q;
  assign bus.instr_cnt = cnt_q;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS datapath.
- Sequences each instruction through IF/ID/EXE/MEM/WB.
- Drives every datapath select and enable: ALU operand-B select (alusrc), ALU op, extender mode, register-destination and write-data muxes, next-PC select, and PC/IR/GRF/DM write enables.
- Sits beside the datapath top; consumes only the IR opcode/funct fields and the ALU zero flag.

Parameters:
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  external hold; freezes state, forces all write enables to 0.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU equal flag, valid in EXE.
- pc_we  out  1  PC write enable.
- npc_sel  out  2  0=PC+4, 1=branch target, 2=j/jal target, 3=GRF[rs] (jalr).
- ir_we  out  1  IR write enable.
- reg_we  out  1  GRF write enable.
- regdst  out  2  0=rt, 1=rd, 2=$31.
- wd_sel  out  2  0=ALU result, 1=DM read data, 2=current PC (already PC+4).
- alusrc  out  1  0=GRF[rt], 1=extended immediate.
- aluop  out  3  0=add, 1=sub, 2=or, 3=lui (imm<<16).
- extop  out  1  0=zero-extend, 1=sign-extend.
- mem_we  out  1  DM write enable.
- state  out  3  current state, for debug.
- instr_cnt  out  CNT_W  retired-instruction count.
- illegal  out  1  one-cycle pulse in ID on an undecoded instruction.

Behaviour:
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4. Register updates on posedge clk or negedge reset.
- Reset low: state=IF, instr_cnt=0. pc_we, ir_we, reg_we, mem_we and illegal are forced 0 combinationally while reset is low. Other outputs follow the IF decode.
- Reset released mid-instruction: restart at IF; no partial write completes.
- Outputs are combinational from state plus opcode/funct (IR is stable after IF).
- IF: ir_we=1, pc_we=1, npc_sel=0. Always go to ID.
- Decode classes:
  - R-ALU: opcode 0, funct 100001 addu / 100011 subu.
  - jalr: opcode 0, funct 001001.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- Paths by class:
  - R-ALU, ori, lui: IF→ID→EXE→WB.
  - lw: IF→ID→EXE→MEM→WB.
  - sw: IF→ID→EXE→MEM.
  - beq: IF→ID→EXE.
  - j, jal, jalr, illegal: IF→ID.
  - After the last state, go to IF; instr_cnt increments by 1 on that transition (wraps at 2^CNT_W).
- ID:
  - j: pc_we=1, npc_sel=2.
  - jal: pc_we=1, npc_sel=2, reg_we=1, regdst=2, wd_sel=2.
  - jalr: pc_we=1, npc_sel=3, reg_we=1, regdst=1, wd_sel=2.
  - illegal: illegal=1, no writes; treated as nop and counted.
- EXE (enables 0 except beq):
  - R: alusrc=0, aluop=0 (addu) or 1 (subu).
  - ori: alusrc=1, extop=0, aluop=2.
  - lui: alusrc=1, aluop=3.
  - lw/sw: alusrc=1, extop=1, aluop=0.
  - beq: alusrc=0, aluop=1, extop=1; pc_we=zero, npc_sel=1.
- EXE select outputs (alusrc, aluop, extop) hold their values through MEM and WB of the same instruction.
- MEM: sw sets mem_we=1. lw has no write.
- WB: reg_we=1.
  - R: regdst=1, wd_sel=0.
  - ori/lui: regdst=0, wd_sel=0.
  - lw: regdst=0, wd_sel=1.
- stall=1: state, instr_cnt and illegal hold; all write enables 0. Select outputs keep their current-state values.
- stall=1 in the same cycle as the last state: neither the transition nor the count occurs.

Decomposition:
- Package mc_pkg: state encodings, opcode/funct constants, npc_sel/regdst/wd_sel/aluop codes.
- Sub-module mc_decode (combinational): opcode/funct → one-hot class vector plus illegal.
- mc_ctrl holds the FSM, output decode and counter.

Test Plan:
- reset low for 3 cycles, then high with IR=addu → all enables 0 during reset. Visit 0,1,2,4,0; reg_we=1 only in WB with regdst=1; instr_cnt=1.
- lw then sw → lw visits 0,1,2,3,4 with wd_sel=1 in WB. sw visits 0,1,2,3 with mem_we=1 only in MEM; alusrc=1 and extop=1 in EXE for both; instr_cnt=2.
- beq with zero=1, then zero=0 → pc_we=1, npc_sel=1 in EXE only when zero=1; 3 cycles each.
- jal and jalr → 2 cycles each. In ID: jal gives regdst=2, wd_sel=2, npc_sel=2; jalr gives regdst=1, npc_sel=3.
- opcode 111111 → illegal pulses 1 cycle in ID, no writes, return to IF, counted. stall=1 held 4 cycles in MEM of sw → state stays 3, mem_we=0, then one mem_we pulse after release.
- reset asserted asynchronously mid-EXE of ori → state=0 immediately; no reg_we pulse occurs; instr_cnt=0.
